// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: byte handshake, baud pacing and frame control for the tsr.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_ctrl #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int ODD_PARITY   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             busy,
    output logic [WIDTH-1:0] tsr_d_in,
    output logic             tsr_ld_sh,
    output logic             tsr_en,
    input  logic             tsr_d_out,
    output logic             txd
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_MAX  = BW'(WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          bit_end;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
`endif

    assign tsr_d_in = tx_data;
    assign bit_end  = (baud_q == BAUD_MAX);
    assign tx_ready = (state_q == IDLE);
    assign busy     = ~tx_ready;

    // State, baud and bit counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state, counter updates and tsr load/shift strobes
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        tsr_en    = 1'b0;
        tsr_ld_sh = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (tx_valid) begin
                    tsr_en    = 1'b1;
                    tsr_ld_sh = 1'b1;
                    state_d   = START;
`ifdef UART_TX_PARITY_EN
                    par_d     = (^tx_data) ^ (ODD_PARITY != 0);
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    tsr_en = 1'b1;
                    baud_d = '0;
                    if (bit_q != BIT_MAX) begin
                        bit_d = bit_q + 1'b1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Serial line level decoded from the registered state
    always_comb begin
        txd = 1'b1;
        unique case (state_q)
            IDLE:   txd = 1'b1;
            START:  txd = 1'b0;
            DATA:   txd = tsr_d_out;
`ifdef UART_TX_PARITY_EN
            PARITY: txd = par_q;
`endif
            STOP:   txd = 1'b1;
            default: txd = 1'b1;
        endcase
    end

endmodule
